// File: rtl/request_index_encoder_pkg.sv
// Shared types and helpers for the request index encoder: FSM state encoding,
// default vector width and a population count usable at any width up to 64.
package request_index_pkg;

  localparam int unsigned N_DEF     = 4;
  localparam int unsigned POP_MAX_N = 64;
  localparam int unsigned POP_W     = 7;

  typedef enum logic {
    IDLE   = 1'b0,
    ENCODE = 1'b1
  } state_t;

  // Callers zero-extend into the wide argument and narrow the result to W+1 bits
  function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX_N-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(POP_MAX_N); i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/request_index_encoder_if.sv
// Request-side and index-side handshake bundle for request_index_encoder.
// The master drives requests and consumes indices; the slave is the encoder.
interface request_index_encoder_if #(
  parameter int unsigned N = request_index_pkg::N_DEF
);
  localparam int unsigned W = $clog2(N);

  logic         enable;
  logic [N-1:0] req_in;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] idx_out;
  logic         idx_valid;
  logic         idx_ready;
  logic         idx_last;
  logic [W:0]   req_count;
  logic         zero_err;

  modport master (
    output enable, req_in, req_valid, idx_ready,
    input  req_ready, idx_out, idx_valid, idx_last, req_count, zero_err
  );

  modport slave (
    input  enable, req_in, req_valid, idx_ready,
    output req_ready, idx_out, idx_valid, idx_last, req_count, zero_err
  );

endinterface

// File: rtl/request_index_encoder_lsb.sv
// Combinational lowest-set-bit encoder: idx is the position of the lowest set
// bit of vec, found flags a non-zero vec (idx is 0 when nothing is set).
module lsb_index_encoder #(
  parameter int unsigned N = request_index_pkg::N_DEF
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);
  localparam int unsigned W = $clog2(N);

  // Scan from the top so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = W'(i);
      end
    end
  end

  assign found = |vec;

endmodule

// File: rtl/request_index_encoder.sv
// Captures a request vector and emits the index of each set bit, lowest first,
// one per idx transfer; reports popcount of the capture and all-zero captures.
module request_index_encoder
  import request_index_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input logic                    clk,
  input logic                    rst,
  request_index_encoder_if.slave bus
);
  localparam int unsigned W  = $clog2(N);
  localparam int unsigned CW = W + 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_pending;
  logic [N-1:0]    w_pending_nxt;
  logic [CW-1:0]   r_req_count;
  logic [CW-1:0]   w_req_count_nxt;
  logic            r_zero_err;
  logic            w_zero_err_nxt;
  logic [W-1:0]    w_idx;
  logic            w_found;
  logic            w_single;

  lsb_index_encoder #(.N(N)) u_lsb (
    .vec   (r_pending),
    .idx   (w_idx),
    .found (w_found)
  );

  // Exactly one bit pending: clearing the lowest set bit leaves nothing
  assign w_single = w_found && ((r_pending & (r_pending - N'(1))) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_req_count <= '0;
      r_zero_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_req_count <= w_req_count_nxt;
      r_zero_err  <= w_zero_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pending_nxt   = r_pending;
    w_req_count_nxt = r_req_count;
    w_zero_err_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid && bus.enable) begin
          w_pending_nxt   = bus.req_in;
          w_req_count_nxt = CW'(popcount(POP_MAX_N'(bus.req_in)));
          if (bus.req_in != '0) begin
            w_state_nxt = ENCODE;
          end else begin
            w_zero_err_nxt = 1'b1;
          end
        end
      end
      ENCODE: begin
        if (bus.idx_ready) begin
          w_pending_nxt = r_pending & ~(N'(1) << w_idx);
          if (w_single) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Index outputs come from pending/state only; req_ready is gated by enable
  assign bus.req_ready = (r_state == IDLE) && bus.enable;
  assign bus.idx_valid = (r_state == ENCODE);
  assign bus.idx_out   = w_idx;
  assign bus.idx_last  = (r_state == ENCODE) && w_single;
  assign bus.req_count = r_req_count;
  assign bus.zero_err  = r_zero_err;

endmodule
